micro_sequencer: RTL and testbench
==================================

// Module: micro_sequencer
// PURPOSE
//  Instruction sequencer directly upstream of the control decoder in the micro-programmed multiplier.
//  - Holds a small loadable program memory of 4-bit opcodes and fetches one opcode at a time.
//  - Drives the decoder's opcode input and the T0/T1/T2 phase strobes.
//  - Supports one hardware loop (start/end address plus repeat count) for the shift-add iterations.
// PARAMETERS
//  ADDR_W  4  program address width; memory depth is 2**ADDR_W
//  OP_W    4  opcode width; must match the decoder opcode input
//  CNT_W   4  loop repeat-counter width
// PORTS
//  clk         in   1       single clock; all state updates on the rising edge
//  reset       in   1       synchronous, active-high reset
//  prog_we     in   1       program-memory write strobe; honoured only in IDLE
//  prog_addr   in   ADDR_W  write address
//  prog_data   in   OP_W    opcode to write
//  prog_last   in   ADDR_W  address of the final instruction; sampled on start
//  loop_start  in   ADDR_W  loop body first address; sampled on start
//  loop_end    in   ADDR_W  loop body last address; sampled on start
//  loop_count  in   CNT_W   extra passes of the body (0 = body runs once); sampled on start
//  start       in   1       begin execution at address 0; honoured only in IDLE
//  opcode      out  OP_W    instruction register, to decoder opcode
//  T0,T1,T2    out  1       one-hot phase strobes (fetch/decode/execute); T2 goes to decoder T2
//  pc          out  ADDR_W  current program counter
//  busy        out  1       high in FETCH, DECODE, EXEC
//  done        out  1       single-cycle pulse after the last instruction's EXEC
// BEHAVIOUR
//  - Reset: state=IDLE; pc=0; ir(opcode)=0; iter=0; all memory words=0.
//    All outputs are 0 after reset. All outputs are registered or decoded from registered state.
//  - FSM states: IDLE -> FETCH -> DECODE -> EXEC -> (FETCH | DONE); DONE -> IDLE.
//  - IDLE:
//    - prog_we writes mem[prog_addr] <= prog_data.
//    - start latches prog_last, loop_start, loop_end and loop_count (into iter), clears pc to 0, and moves to FETCH.
//    - If prog_we and start arrive in the same cycle, the write completes first, so a write to address 0 is fetched.
//  - FETCH (T0=1): ir <= mem[pc]. opcode changes only in this state.
//  - DECODE (T1=1): no state change; gives the decoder a settle cycle.
//  - EXEC (T2=1): next pc, evaluated in priority order:
//    1. pc==loop_end && iter!=0 -> pc <= loop_start; iter <= iter-1; go to FETCH.
//    2. pc==prog_last -> go to DONE; pc holds.
//    3. Otherwise pc <= pc+1 (wraps modulo 2**ADDR_W); go to FETCH.
//  - DONE: done=1 for exactly one cycle, then IDLE. opcode and pc hold their last values.
//  - Timing: each instruction takes 3 cycles. With no loop taken, done is high in cycle 3*(prog_last+1)+1 after the start cycle.
//  - Ignored inputs: start and prog_we are ignored when busy or in DONE. Latched loop and length values are immune to input changes mid-run.
//  - loop_end never reached (e.g. beyond prog_last): the loop is silently unused.
//  - loop_start > loop_end: legal forward jump.
//  - loop_count=0: no repeat.
//  - Reset mid-run: immediate return to reset state on the next edge. Memory is cleared and must be reloaded.
//  - Exactly one of T0/T1/T2 is high while busy; none is high otherwise.
// STRUCTURE
//  - Shared package (seq_pkg): state encoding (IDLE, FETCH, DECODE, EXEC, DONE, one-hot) and the ADDR_W/OP_W/CNT_W defaults.
//  - One natural sub-module: prog_mem, a 2**ADDR_W x OP_W register file with synchronous write, combinational read and synchronous reset.
//  - FSM, pc, iter and ir live in the top module.
// TESTING
//  1. Reset: assert reset 2 cycles with random inputs -> opcode=0, pc=0, T0/T1/T2=0, busy=0, done=0.
//  2. Linear program: load mem[0..2]=1,2,15; prog_last=2; loop_end=15; start -> T0,T1,T2 cycle ×3.
//     opcode sequence 1,2,15; done pulses in cycle 10 after start; then IDLE.
//  3. Loop: mem[0]=0, mem[1]=8, mem[2]=3, mem[3]=2; loop_start=1; loop_end=2; loop_count=3; prog_last=3.
//     Executed pc order 0,1,2,1,2,1,2,1,2,3; done in cycle 31 after start.
//  4. Protection: during a run, pulse prog_we (addr 1, data 9) and start -> memory unchanged, run unaffected.
//     Rerun after done -> identical opcode trace.
//  5. Boundaries:
//     - Same-cycle prog_we(addr 0, data 5) + start -> first opcode 5.
//     - prog_last=15 with all 16 words -> pc reaches 15, done, no wrap.
//  6. Reset mid-run: assert reset during DECODE of instruction 2 -> next cycle IDLE, memory zeroed.
//     Restart without reload -> opcode 0 fetched.

Source files
------------

// File: rtl/seq_pkg.sv
// Shared definitions for the micro-sequencer: default widths and the one-hot
// FSM state encoding used by the top module.
package seq_pkg;

    localparam int ADDR_W_DEF = 4;
    localparam int OP_W_DEF   = 4;
    localparam int CNT_W_DEF  = 4;

    // One-hot so each phase strobe is a single state bit.
    typedef enum logic [4:0] {
        S_IDLE   = 5'b00001,
        S_FETCH  = 5'b00010,
        S_DECODE = 5'b00100,
        S_EXEC   = 5'b01000,
        S_DONE   = 5'b10000
    } state_t;

    // True for the three instruction phases.
    function automatic logic state_is_busy(input state_t s);
        return (s == S_FETCH) || (s == S_DECODE) || (s == S_EXEC);
    endfunction

endpackage

// File: rtl/prog_mem.sv
// Program memory: 2**ADDR_W x OP_W register file, synchronous write,
// combinational read, synchronous clear on reset.
module prog_mem #(
    parameter int ADDR_W = 4,
    parameter int OP_W   = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [OP_W-1:0]   wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [OP_W-1:0]   rdata
);

    localparam int DEPTH = 2 ** ADDR_W;

    logic [DEPTH-1:0][OP_W-1:0] mem_q;
    logic [DEPTH-1:0][OP_W-1:0] mem_d;

    // Next memory image: a single word replaced when the write strobe is up.
    always_comb begin
        mem_d = mem_q;
        if (we) begin
            mem_d[waddr] = wdata;
        end
    end

    // Storage; reset wipes every word so a program must be reloaded.
    always_ff @(posedge clk) begin
        if (reset) begin
            mem_q <= '0;
        end else begin
            mem_q <= mem_d;
        end
    end

    assign rdata = mem_q[raddr];

endmodule

// File: rtl/micro_sequencer.sv
// Micro-sequencer feeding the control decoder: fetches 4-bit opcodes from a
// loadable program memory, sequences FETCH/DECODE/EXEC phases, and supports a
// single hardware loop with a repeat counter.
module micro_sequencer
    import seq_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int OP_W   = OP_W_DEF,
    parameter int CNT_W  = CNT_W_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              prog_we,
    input  logic [ADDR_W-1:0] prog_addr,
    input  logic [OP_W-1:0]   prog_data,
    input  logic [ADDR_W-1:0] prog_last,
    input  logic [ADDR_W-1:0] loop_start,
    input  logic [ADDR_W-1:0] loop_end,
    input  logic [CNT_W-1:0]  loop_count,
    input  logic              start,
    output logic [OP_W-1:0]   opcode,
    output logic              T0,
    output logic              T1,
    output logic              T2,
    output logic [ADDR_W-1:0] pc,
    output logic              busy,
    output logic              done
);

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [OP_W-1:0]   ir_q, ir_d;
    logic [CNT_W-1:0]  iter_q, iter_d;
    logic [ADDR_W-1:0] last_q, last_d;
    logic [ADDR_W-1:0] lstart_q, lstart_d;
    logic [ADDR_W-1:0] lend_q, lend_d;

    logic              mem_we;
    logic [OP_W-1:0]   mem_rdata;

    // Writes are only accepted while parked in IDLE; a write coinciding with
    // start lands on the same edge, so FETCH already sees it.
    assign mem_we = prog_we && (state_q == S_IDLE);

    prog_mem #(
        .ADDR_W (ADDR_W),
        .OP_W   (OP_W)
    ) u_prog_mem (
        .clk   (clk),
        .reset (reset),
        .we    (mem_we),
        .waddr (prog_addr),
        .wdata (prog_data),
        .raddr (pc_q),
        .rdata (mem_rdata)
    );

    // Next-state and datapath update for the sequencer FSM.
    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        ir_d     = ir_q;
        iter_d   = iter_q;
        last_d   = last_q;
        lstart_d = lstart_q;
        lend_d   = lend_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    last_d   = prog_last;
                    lstart_d = loop_start;
                    lend_d   = loop_end;
                    iter_d   = loop_count;
                    pc_d     = '0;
                    state_d  = S_FETCH;
                end
            end
            S_FETCH: begin
                ir_d    = mem_rdata;
                state_d = S_DECODE;
            end
            S_DECODE: begin
                state_d = S_EXEC;
            end
            S_EXEC: begin
                // Loop-back outranks program end, so a loop ending on the last
                // instruction still runs all its passes.
                if ((pc_q == lend_q) && (iter_q != '0)) begin
                    pc_d    = lstart_q;
                    iter_d  = iter_q - CNT_W'(1);
                    state_d = S_FETCH;
                end else if (pc_q == last_q) begin
                    state_d = S_DONE;
                end else begin
                    pc_d    = pc_q + ADDR_W'(1);
                    state_d = S_FETCH;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State, program counter, instruction register and latched run settings.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_IDLE;
            pc_q     <= '0;
            ir_q     <= '0;
            iter_q   <= '0;
            last_q   <= '0;
            lstart_q <= '0;
            lend_q   <= '0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            ir_q     <= ir_d;
            iter_q   <= iter_d;
            last_q   <= last_d;
            lstart_q <= lstart_d;
            lend_q   <= lend_d;
        end
    end

    assign opcode = ir_q;
    assign pc     = pc_q;
    assign T0     = (state_q == S_FETCH);
    assign T1     = (state_q == S_DECODE);
    assign T2     = (state_q == S_EXEC);
    assign busy   = state_is_busy(state_q);
    assign done   = (state_q == S_DONE);

endmodule

// File: tb/tb_micro_sequencer.sv
// Directed bench for micro_sequencer: table of programs with expected
// pc/opcode traces and done timing, plus hand-written corner sequences.
module tb_micro_sequencer;

    logic       clk;
    logic       reset;
    logic       prog_we;
    logic [3:0] prog_addr;
    logic [3:0] prog_data;
    logic [3:0] prog_last;
    logic [3:0] loop_start;
    logic [3:0] loop_end;
    logic [3:0] loop_count;
    logic       start;
    logic [3:0] opcode;
    logic       T0, T1, T2;
    logic [3:0] pc;
    logic       busy;
    logic       done;

    int checks = 0;
    int errors = 0;

    micro_sequencer dut (
        .clk        (clk),
        .reset      (reset),
        .prog_we    (prog_we),
        .prog_addr  (prog_addr),
        .prog_data  (prog_data),
        .prog_last  (prog_last),
        .loop_start (loop_start),
        .loop_end   (loop_end),
        .loop_count (loop_count),
        .start      (start),
        .opcode     (opcode),
        .T0         (T0),
        .T1         (T1),
        .T2         (T2),
        .pc         (pc),
        .busy       (busy),
        .done       (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [0:15][3:0] mem;
        int               nwords;
        logic [3:0]       last;
        logic [3:0]       ls;
        logic [3:0]       le;
        logic [3:0]       lc;
        int               ncyc;
        int               nins;
        logic [0:15][3:0] pcs;
        logic [0:15][3:0] ops;
    } vec_t;

    vec_t vecs[5];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic load(input vec_t v);
        for (int i = 0; i < v.nwords; i++) begin
            @(negedge clk);
            prog_we   = 1'b1;
            prog_addr = 4'(i);
            prog_data = v.mem[i];
        end
        @(negedge clk);
        prog_we = 1'b0;
    endtask

    // Leaves the bench at the falling edge of cycle 1 (first FETCH).
    task automatic launch(input vec_t v, input bit wr0);
        @(negedge clk);
        prog_last  = v.last;
        loop_start = v.ls;
        loop_end   = v.le;
        loop_count = v.lc;
        start      = 1'b1;
        if (wr0) begin
            prog_we   = 1'b1;
            prog_addr = 4'd0;
            prog_data = 4'd5;
        end
        @(negedge clk);
        start   = 1'b0;
        prog_we = 1'b0;
    endtask

    // Follows a run cycle by cycle, recording pc/opcode in each DECODE phase.
    task automatic trace(input vec_t v, input string tag, input int dis_cyc);
        logic [3:0] got_pc[16];
        logic [3:0] got_op[16];
        int n;
        bit seen;
        int oh;
        n = 0;
        seen = 1'b0;
        for (int cyc = 1; cyc <= 80 && !seen; cyc++) begin
            oh = int'(T0) + int'(T1) + int'(T2);
            chk({tag, " phase_onehot"}, 32'(oh), done ? 32'd0 : 32'd1);
            chk({tag, " busy"}, 32'(busy), done ? 32'd0 : 32'd1);
            if (T1) begin
                if (n < 16) begin
                    got_pc[n] = pc;
                    got_op[n] = opcode;
                end
                n++;
            end
            if (done) begin
                seen = 1'b1;
                chk({tag, " done_cycle"}, 32'(cyc), 32'(v.ncyc));
            end
            if (dis_cyc != 0 && cyc == dis_cyc) begin
                prog_we    = 1'b1;
                prog_addr  = 4'd1;
                prog_data  = 4'd9;
                start      = 1'b1;
                prog_last  = 4'd0;
                loop_end   = 4'd0;
                loop_count = 4'd0;
            end else if (dis_cyc != 0 && cyc == dis_cyc + 1) begin
                prog_we = 1'b0;
                start   = 1'b0;
            end
            @(negedge clk);
        end
        if (!seen) begin
            checks++;
            errors++;
            $display("FAIL %s timeout: done never seen, required by cycle %0d", tag, v.ncyc);
        end
        chk({tag, " done_single"}, 32'(done), 32'd0);
        chk({tag, " idle_after"}, 32'(busy), 32'd0);
        chk({tag, " n_instr"}, 32'(n), 32'(v.nins));
        for (int i = 0; i < v.nins && i < n && i < 16; i++) begin
            chk($sformatf("%s pc[%0d]", tag, i), 32'(got_pc[i]), 32'(v.pcs[i]));
            chk($sformatf("%s op[%0d]", tag, i), 32'(got_op[i]), 32'(v.ops[i]));
        end
    endtask

    initial begin
        // 0: linear program
        vecs[0].mem = 64'h12F0000000000000; vecs[0].nwords = 3;
        vecs[0].last = 4'd2; vecs[0].ls = 4'd0; vecs[0].le = 4'd15; vecs[0].lc = 4'd0;
        vecs[0].ncyc = 10; vecs[0].nins = 3;
        vecs[0].pcs = 64'h0120000000000000; vecs[0].ops = 64'h12F0000000000000;
        // 1: hardware loop, three extra passes over 1..2
        vecs[1].mem = 64'h0832000000000000; vecs[1].nwords = 4;
        vecs[1].last = 4'd3; vecs[1].ls = 4'd1; vecs[1].le = 4'd2; vecs[1].lc = 4'd3;
        vecs[1].ncyc = 31; vecs[1].nins = 10;
        vecs[1].pcs = 64'h0121212123000000; vecs[1].ops = 64'h0838383832000000;
        // 2: full 16-word program, last address 15
        vecs[2].mem = 64'hFEDCBA9876543210; vecs[2].nwords = 16;
        vecs[2].last = 4'd15; vecs[2].ls = 4'd0; vecs[2].le = 4'd15; vecs[2].lc = 4'd0;
        vecs[2].ncyc = 49; vecs[2].nins = 16;
        vecs[2].pcs = 64'h0123456789ABCDEF; vecs[2].ops = 64'hFEDCBA9876543210;
        // 3: single instruction written in the start cycle
        vecs[3].mem = '0; vecs[3].nwords = 0;
        vecs[3].last = 4'd0; vecs[3].ls = 4'd0; vecs[3].le = 4'd15; vecs[3].lc = 4'd0;
        vecs[3].ncyc = 4; vecs[3].nins = 1;
        vecs[3].pcs = 64'h0; vecs[3].ops = 64'h5000000000000000;
        // 4: restart after mid-run reset, memory cleared
        vecs[4].mem = '0; vecs[4].nwords = 0;
        vecs[4].last = 4'd2; vecs[4].ls = 4'd0; vecs[4].le = 4'd15; vecs[4].lc = 4'd0;
        vecs[4].ncyc = 10; vecs[4].nins = 3;
        vecs[4].pcs = 64'h0120000000000000; vecs[4].ops = 64'h0;

        // Reset with random inputs toggling
        reset = 1'b1;
        for (int i = 0; i < 2; i++) begin
            prog_we    = 1'($urandom);
            prog_addr  = 4'($urandom);
            prog_data  = 4'($urandom);
            prog_last  = 4'($urandom);
            loop_start = 4'($urandom);
            loop_end   = 4'($urandom);
            loop_count = 4'($urandom);
            start      = 1'($urandom);
            @(posedge clk);
        end
        @(negedge clk);
        chk("rst opcode", 32'(opcode), 32'd0);
        chk("rst pc", 32'(pc), 32'd0);
        chk("rst phases", 32'({T0, T1, T2}), 32'd0);
        chk("rst busy", 32'(busy), 32'd0);
        chk("rst done", 32'(done), 32'd0);
        prog_we = 1'b0; start = 1'b0;
        prog_addr = '0; prog_data = '0;
        reset = 1'b0;

        // Table-driven runs
        for (int k = 0; k < 3; k++) begin
            load(vecs[k]);
            launch(vecs[k], 1'b0);
            trace(vecs[k], $sformatf("vec%0d", k), 0);
        end
        chk("full pc_hold_no_wrap", 32'(pc), 32'd15);
        chk("full opcode_hold", 32'(opcode), 32'd0);

        // Protection: writes, start and input changes mid-run are ignored
        load(vecs[1]);
        launch(vecs[1], 1'b0);
        trace(vecs[1], "protect", 5);
        launch(vecs[1], 1'b0);
        trace(vecs[1], "rerun", 0);

        // Write to address 0 coincident with start is fetched
        launch(vecs[3], 1'b1);
        trace(vecs[3], "same_cycle_wr", 0);

        // Reset during DECODE of the second instruction
        load(vecs[2]);
        launch(vecs[2], 1'b0);
        repeat (4) @(negedge clk);
        chk("midrst pre T1", 32'(T1), 32'd1);
        chk("midrst pre pc", 32'(pc), 32'd1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("midrst busy", 32'(busy), 32'd0);
        chk("midrst pc", 32'(pc), 32'd0);
        chk("midrst opcode", 32'(opcode), 32'd0);
        chk("midrst phases", 32'({T0, T1, T2}), 32'd0);
        launch(vecs[4], 1'b0);
        trace(vecs[4], "after_rst", 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
